// File: rtl/lut_addsub_pipe_if.sv
// Operand/result bundle for the carry-pipelined add/sub unit.
// The master issues operations, the slave returns tagged results.
interface lut_addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             valid_in;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             ovf;
    logic             valid_out;

    modport master (
        output en, valid_in, op, a, b,
        input  y, ovf, valid_out
    );

    modport slave (
        input  en, valid_in, op, a, b,
        output y, ovf, valid_out
    );
endinterface

// File: rtl/lut_addsub_pipe.sv
// Carry-pipelined add/subtract: one slice per stage, operands skewed in,
// partial sums carried forward so every result bit leaves on one cycle.
module lut_addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic               clock,
    input logic               reset,
    lut_addsub_pipe_if.slave  bus
);
    localparam int SL = (WIDTH + STAGES - 1) / STAGES;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_s;
        logic [WIDTH-1:0] bx_s;
        logic [WIDTH-1:0] y_s;
        logic             c_s;
        logic             v_s;
        logic [WIDTH-1:0] y_d;
        logic             c_d;
        logic [WIDTH-1:0] y_q;
        logic             v_q;

        // Stage 0 takes the bus; subtract is a + ~b with carry-in 1.
        if (k == 0) begin : g_first
            assign a_s  = bus.a;
            assign bx_s = bus.b ^ {WIDTH{bus.op}};
            assign y_s  = '0;
            assign c_s  = bus.op;
            assign v_s  = bus.valid_in;
        end else begin : g_next
            assign a_s  = g_stage[k-1].g_skew.a_q;
            assign bx_s = g_stage[k-1].g_skew.bx_q;
            assign y_s  = g_stage[k-1].y_q;
            assign c_s  = g_stage[k-1].g_skew.c_q;
            assign v_s  = g_stage[k-1].v_q;
        end

        // Ripple this stage's slice onto the partial sum from below.
        always_comb begin
            y_d = y_s;
            c_d = c_s;
            for (int i = 0; i < WIDTH; i++) begin
                if (i / SL == k) begin
                    y_d[i] = a_s[i] ^ bx_s[i] ^ c_d;
                    c_d    = (a_s[i] & bx_s[i])
                           | (c_d & (a_s[i] ^ bx_s[i]));
                end
            end
        end

        // Partial result and valid tag advance together on en.
        always_ff @(posedge clock) begin
            if (reset) begin
                y_q <= '0;
                v_q <= 1'b0;
            end else if (bus.en) begin
                y_q <= y_d;
                v_q <= v_s;
            end
        end

        // Skewed operands and slice carry feed the next stage only.
        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] bx_q;
            logic             c_q;

            // Operand skew and carry registers share the pipe enable.
            always_ff @(posedge clock) begin
                if (reset) begin
                    a_q  <= '0;
                    bx_q <= '0;
                    c_q  <= 1'b0;
                end else if (bus.en) begin
                    a_q  <= a_s;
                    bx_q <= bx_s;
                    c_q  <= c_d;
                end
            end
        end

        // Signed overflow needs the top sign bits, so it lives last.
        if (k == STAGES - 1) begin : g_last
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = (a_s[WIDTH-1] == bx_s[WIDTH-1])
                         && (y_d[WIDTH-1] != a_s[WIDTH-1]);

            // Overflow flag registered alongside the final slice.
            always_ff @(posedge clock) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (bus.en) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign bus.y         = g_stage[STAGES-1].y_q;
    assign bus.valid_out = g_stage[STAGES-1].v_q;
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_lut_addsub_pipe.sv
// Bench for lut_addsub_pipe: directed vectors on 8/2,
// random streams on 13/4 and 8/1 against a delayed a+-b model.
module tb_lut_addsub_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lut_addsub_pipe_if #(.WIDTH(8))  bus8  ();
    lut_addsub_pipe_if #(.WIDTH(13)) bus13 ();
    lut_addsub_pipe_if #(.WIDTH(8))  bus81 ();

    lut_addsub_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clock(clk), .reset(rst), .bus(bus8)
    );
    lut_addsub_pipe #(.WIDTH(13), .STAGES(4)) dut13 (
        .clock(clk), .reset(rst), .bus(bus13)
    );
    lut_addsub_pipe #(.WIDTH(8), .STAGES(1)) dut81 (
        .clock(clk), .reset(rst), .bus(bus81)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic o,
                         input logic [7:0] a, input logic [7:0] b);
        bus8.valid_in = v;
        bus8.op       = o;
        bus8.a        = a;
        bus8.b        = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic run_one(input string tag, input logic o,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ey, input logic eo);
        drive(1'b1, o, a, b);
        tick();
        idle();
        check({tag, " early"}, 64'(bus8.valid_out), 64'd0);
        tick();
        check({tag, " vout"}, 64'(bus8.valid_out), 64'd1);
        check({tag, " y"}, 64'(bus8.y), 64'(ey));
        check({tag, " ovf"}, 64'(bus8.ovf), 64'(eo));
    endtask

    function automatic void ref_op(input int w, input logic o,
                                   input logic [63:0] a,
                                   input logic [63:0] b,
                                   output logic [63:0] y,
                                   output logic ovf);
        logic [63:0] m;
        logic sa, sb, sy;
        m  = (64'd1 << w) - 64'd1;
        y  = (o ? (a - b) : (a + b)) & m;
        sa = a[w-1];
        sb = b[w-1];
        sy = y[w-1];
        ovf = o ? ((sa != sb) && (sy != sa))
                : ((sa == sb) && (sy != sa));
    endfunction

    logic [63:0] m13_y [4];
    logic        m13_v [4];
    logic        m13_o [4];
    logic [63:0] m81_y;
    logic        m81_v;
    logic        m81_o;

    initial begin
        idle();
        bus8.en = 1'b1;
        bus13.en = 1'b0; bus13.valid_in = 1'b0; bus13.op = 1'b0;
        bus13.a = '0;    bus13.b = '0;
        bus81.en = 1'b0; bus81.valid_in = 1'b0; bus81.op = 1'b0;
        bus81.a = '0;    bus81.b = '0;
        for (int i = 0; i < 4; i++) begin
            m13_y[i] = '0; m13_v[i] = 1'b0; m13_o[i] = 1'b0;
        end
        m81_y = '0; m81_v = 1'b0; m81_o = 1'b0;

        repeat (16) tick();
        rst = 1'b0;
        check("rst vout", 64'(bus8.valid_out), 64'd0);
        check("rst y", 64'(bus8.y), 64'd0);
        check("rst ovf", 64'(bus8.ovf), 64'd0);
        check("rst13 vout", 64'(bus13.valid_out), 64'd0);
        check("rst81 y", 64'(bus81.y), 64'd0);
        tick();

        run_one("t1 sub 1,-3", 1'b1, 8'h01, 8'hFD, 8'h04, 1'b0);
        run_one("t2 add 1,-3", 1'b0, 8'h01, 8'hFD, 8'hFE, 1'b0);
        run_one("t2 add 7f,1", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b1);
        run_one("t3 sub 80,1", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1);
        run_one("t3 sub 0,0", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);

        drive(1'b1, 1'b0, 8'h05, 8'h06);
        tick();
        drive(1'b1, 1'b1, 8'h05, 8'h06);
        tick();
        check("t4 v0", 64'(bus8.valid_out), 64'd1);
        check("t4 y0", 64'(bus8.y), 64'h0B);
        drive(1'b1, 1'b0, 8'hFF, 8'h01);
        tick();
        check("t4 v1", 64'(bus8.valid_out), 64'd1);
        check("t4 y1", 64'(bus8.y), 64'hFF);
        check("t4 o1", 64'(bus8.ovf), 64'd0);
        idle();
        tick();
        check("t4 v2", 64'(bus8.valid_out), 64'd1);
        check("t4 y2", 64'(bus8.y), 64'h00);
        check("t4 o2", 64'(bus8.ovf), 64'd0);
        tick();
        check("t4 tail", 64'(bus8.valid_out), 64'd0);

        drive(1'b1, 1'b0, 8'h10, 8'h20);
        tick();
        bus8.en = 1'b0;
        drive(1'b1, 1'b0, 8'h55, 8'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5 hold v", 64'(bus8.valid_out), 64'd0);
            check("t5 hold y", 64'(bus8.y), 64'd0);
            check("t5 hold o", 64'(bus8.ovf), 64'd0);
        end
        bus8.en = 1'b1;
        idle();
        tick();
        check("t5 v", 64'(bus8.valid_out), 64'd1);
        check("t5 y", 64'(bus8.y), 64'h30);
        tick();
        check("t5 drop", 64'(bus8.valid_out), 64'd0);

        drive(1'b1, 1'b0, 8'h11, 8'h22);
        tick();
        drive(1'b1, 1'b0, 8'h33, 8'h44);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("t6 v", 64'(bus8.valid_out), 64'd0);
        check("t6 y", 64'(bus8.y), 64'd0);
        check("t6 o", 64'(bus8.ovf), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6 stale", 64'(bus8.valid_out), 64'd0);
        end
        run_one("t6 after", 1'b0, 8'h02, 8'h03, 8'h05, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            logic e, v, o13, o81;
            logic [63:0] a13, b13, a81, b81, ry;
            logic ro;
            e   = ($urandom_range(0, 7) != 0);
            v   = ($urandom_range(0, 3) != 0);
            o13 = 1'($urandom);
            o81 = 1'($urandom);
            a13 = 64'($urandom & 32'h1FFF);
            b13 = 64'($urandom & 32'h1FFF);
            a81 = 64'($urandom & 32'hFF);
            b81 = 64'($urandom & 32'hFF);
            bus13.en = e; bus13.valid_in = v; bus13.op = o13;
            bus13.a = a13[12:0]; bus13.b = b13[12:0];
            bus81.en = e; bus81.valid_in = v; bus81.op = o81;
            bus81.a = a81[7:0]; bus81.b = b81[7:0];
            tick();
            if (e) begin
                for (int k = 3; k > 0; k--) begin
                    m13_y[k] = m13_y[k-1];
                    m13_v[k] = m13_v[k-1];
                    m13_o[k] = m13_o[k-1];
                end
                ref_op(13, o13, a13, b13, ry, ro);
                m13_y[0] = ry; m13_v[0] = v; m13_o[0] = ro;
                ref_op(8, o81, a81, b81, ry, ro);
                m81_y = ry; m81_v = v; m81_o = ro;
            end
            check("r13 vout", 64'(bus13.valid_out), 64'(m13_v[3]));
            check("r81 vout", 64'(bus81.valid_out), 64'(m81_v));
            if (m13_v[3]) begin
                check("r13 y", 64'(bus13.y), m13_y[3]);
                check("r13 ovf", 64'(bus13.ovf), 64'(m13_o[3]));
            end
            if (m81_v) begin
                check("r81 y", 64'(bus81.y), m81_y);
                check("r81 ovf", 64'(bus81.ovf), 64'(m81_o));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
